sram_rw_arbiter: RTL and testbench
==================================

Name: sram_rw_arbiter

Overview:
- Shares the single read/write port (port 0) of the 32x256 byte-masked OpenRAM macro between two requesters: m0 (core load/store unit) and m1 (Wishbone host bridge).
- Round-robin arbitration with one command issued per cycle and a fixed 2-cycle response latency.
- Read data and write acknowledges are routed back to the originating requester in issue order.
- Sits between the requesters and the SRAM macro; the macro's port 1 (read-only) is wired elsewhere and is not touched.

Parameters:
- ADDR_WIDTH, 8, SRAM word address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- NUM_WMASKS, DATA_WIDTH/8, byte-lane write mask width.

Ports:
- wb_clk_i  in  1  clock; also drives the SRAM clk0 at top level.
- wb_rst_i  in  1  asynchronous active-high reset.
- mN_req_valid  in  1  request valid (N = 0, 1; the same port set is repeated per requester).
- mN_req_ready  out  1  request accepted this cycle.
- mN_req_we  in  1  1 = write, 0 = read.
- mN_req_wmask  in  NUM_WMASKS  byte-lane enables; ignored on reads.
- mN_req_addr  in  ADDR_WIDTH  word address.
- mN_req_wdata  in  DATA_WIDTH  write data.
- mN_rsp_valid  out  1  one-cycle response strobe.
- mN_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- mN_rsp_err  out  1  valid with rsp_valid; write was blocked.
- m1_wprot  in  1  write-protect for m1, sampled at issue.
- sram_csb0  out  1  active-low chip select.
- sram_web0  out  1  active-low write enable.
- sram_wmask0  out  NUM_WMASKS  byte mask.
- sram_addr0  out  ADDR_WIDTH  address.
- sram_din0  out  DATA_WIDTH  write data.
- sram_dout0  in  DATA_WIDTH  read data from the macro.

Behaviour:
- Reset (async, wb_rst_i=1):
  - All rsp_valid/rsp_err = 0, rsp_rdata = 0.
  - sram_csb0 = 1, sram_web0 = 1.
  - Round-robin pointer = m0 preferred.
  - Pipeline stages cleared. A command in flight is dropped; no response is ever produced for it.
- Arbitration (combinational in cycle T):
  - Only one requester valid: it is granted.
  - Both valid: the requester opposite the last granted one wins.
  - The pointer updates only on a grant.
  - req_ready is high only for the granted requester; there is no bubble between grants.
- Issue (cycle T, grant present):
  - sram_csb0 = 0.
  - sram_web0 = ~we.
  - Address, wmask and data are driven combinationally from the winner.
  - No grant: sram_csb0 = 1; other SRAM outputs hold their last value.
- Write protect: m1 write with m1_wprot=1:
  - Still granted.
  - sram_csb0 stays 1 (no SRAM access).
  - Response flagged err = 1.
- Pipeline:
  - Stage S1 (end of T) records {valid, owner, is_read, err}.
  - The SRAM model updates its output after the falling edge of T+1. At the end of T+1 the block captures sram_dout0 into the response data register when S1 is a read.
  - Stage S2 is visible in cycle T+2: owner's rsp_valid = 1, rsp_rdata = captured data for reads, 0 for writes.
- Latency is exactly 2 cycles for every accepted request, and responses come back in issue order.
- Throughput is 1 request per cycle aggregate.
- Responses have no backpressure; requesters must accept them in the cycle they appear.
- Hazards:
  - Back-to-back write then read of the same address: the read returns the new data. The macro writes on the falling edge of T and reads on the falling edge of T+1.
  - The block does no forwarding.
- Unused rsp ports hold 0 when no response is present.

Decomposition:
- Shared package sram_ctrl_pkg: constants OWNER_M0 = 0, OWNER_M1 = 1, and a packed pipeline-tag struct {valid, owner, is_read, err}.
- One natural sub-module: rr_arbiter2 (2-way round-robin with last-grant pointer, async reset).
- Pipeline and mux logic stay in the top module.

Test Plan:
- Reset mid-flight: m0 read issued, wb_rst_i pulsed in the next cycle -> no m0_rsp_valid ever; sram_csb0=1 during reset.
- m0 write addr 0x10, data 0xDEADBEEF, wmask 4'b1111; then m0 read 0x10 -> rsp_valid 2 cycles after the read is accepted, rdata=0xDEADBEEF, err=0.
- Partial write wmask 4'b0100 with data 0x00AA0000 to the same word -> read returns 0xDEAABEEF.
- Both valid continuously, 6 reads at distinct addresses -> grants alternate m0,m1,m0,m1…; each response lands on the correct port with the matching data.
- m1_wprot=1, m1 write 0x12345678 to 0x20 -> sram_csb0 stays 1; m1_rsp_err=1 at T+2; later read of 0x20 returns the old value.
- m0 write 0x5A5A5A5A to 0x30 in cycle T and m1 read of 0x30 in T+1 -> m1 rdata=0x5A5A5A5A.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM port-0 arbiter slice.
package sram_ctrl_pkg;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic is_read;
    logic err;
  } pipe_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on contention the requester opposite the last grant wins.
module rr_arbiter2
  import sram_ctrl_pkg::*;
(
  input  logic clk0,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_owner;

  // Grants are suppressed while reset is held so nothing reaches the macro.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        gnt0 = (last_owner == OWNER_M1);
        gnt1 = (last_owner == OWNER_M0);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      last_owner <= OWNER_M1;
    end else if (gnt0 || gnt1) begin
      last_owner <= gnt1 ? OWNER_M1 : OWNER_M0;
    end
  end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Shares SRAM port 0 between m0 and m1: one command per cycle, responses fixed 2 cycles later.
module sram_rw_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,

  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [NUM_WMASKS-1:0] m0_req_wmask,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  output logic                  m0_rsp_err,

  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [NUM_WMASKS-1:0] m1_req_wmask,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  m1_rsp_err,
  input  logic                  m1_wprot,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  logic                  gnt0, gnt1, grant, win_we, blocked;
  logic [NUM_WMASKS-1:0] win_wmask, wmask_q;
  logic [ADDR_WIDTH-1:0] win_addr, addr_q;
  logic [DATA_WIDTH-1:0] win_wdata, din_q, rdata_q;
  logic                  web_q;
  pipe_tag_t             s1_d, s1, s2;

  rr_arbiter2 u_arb (
    .clk0 (wb_clk_i),
    .rst  (wb_rst_i),
    .req0 (m0_req_valid),
    .req1 (m1_req_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign m0_req_ready = gnt0;
  assign m1_req_ready = gnt1;
  assign grant        = gnt0 | gnt1;

  assign win_we    = gnt1 ? m1_req_we    : m0_req_we;
  assign win_wmask = gnt1 ? m1_req_wmask : m0_req_wmask;
  assign win_addr  = gnt1 ? m1_req_addr  : m0_req_addr;
  assign win_wdata = gnt1 ? m1_req_wdata : m0_req_wdata;

  // A protected m1 write is still accepted and acknowledged, but never touches the macro.
  assign blocked = gnt1 & m1_req_we & m1_wprot;

  assign sram_csb0   = ~(grant & ~blocked);
  assign sram_web0   = grant ? ~win_we   : web_q;
  assign sram_wmask0 = grant ? win_wmask : wmask_q;
  assign sram_addr0  = grant ? win_addr  : addr_q;
  assign sram_din0   = grant ? win_wdata : din_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else if (grant) begin
      web_q   <= ~win_we;
      wmask_q <= win_wmask;
      addr_q  <= win_addr;
      din_q   <= win_wdata;
    end
  end

  always_comb begin
    s1_d         = '0;
    s1_d.valid   = grant;
    s1_d.owner   = gnt1 ? OWNER_M1 : OWNER_M0;
    s1_d.is_read = grant & ~win_we;
    s1_d.err     = blocked;
  end

  // Macro output for an S1 read settles after the mid-cycle falling edge; sample it at the end of that cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1      <= '0;
      s2      <= '0;
      rdata_q <= '0;
    end else begin
      s1      <= s1_d;
      s2      <= s1;
      rdata_q <= (s1.valid && s1.is_read) ? sram_dout0 : '0;
    end
  end

  assign m0_rsp_valid = s2.valid && (s2.owner == OWNER_M0);
  assign m1_rsp_valid = s2.valid && (s2.owner == OWNER_M1);
  assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : '0;
  assign m0_rsp_err   = m0_rsp_valid & s2.err;
  assign m1_rsp_err   = m1_rsp_valid & s2.err;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Directed bench for sram_rw_arbiter with a behavioural byte-masked SRAM on port 0.
module tb_sram_rw_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        m0_req_valid = 1'b0, m0_req_we = 1'b0;
  logic [3:0]  m0_req_wmask = '0;
  logic [7:0]  m0_req_addr = '0;
  logic [31:0] m0_req_wdata = '0;
  logic        m1_req_valid = 1'b0, m1_req_we = 1'b0, m1_wprot = 1'b0;
  logic [3:0]  m1_req_wmask = '0;
  logic [7:0]  m1_req_addr = '0;
  logic [31:0] m1_req_wdata = '0;
  logic        m0_req_ready, m1_req_ready;
  logic        m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0;

  int checks = 0;
  int failures = 0;

  sram_rw_arbiter dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_wmask(m0_req_wmask), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_wmask(m1_req_wmask), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .m1_wprot(m1_wprot),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Macro model: writes on the falling edge of the issue cycle, read data appears on the next falling edge.
  logic [31:0] mem [0:255];
  logic        rd_pend = 1'b0;
  logic [7:0]  rd_addr = '0;

  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(negedge wb_clk_i) begin
    if (rd_pend) sram_dout0 = mem[rd_addr];
    if (!sram_csb0 && !sram_web0)
      for (int b = 0; b < 4; b++)
        if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] = sram_din0[8*b +: 8];
    rd_pend = !sram_csb0 && sram_web0;
    rd_addr = sram_addr0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic set_m0(input logic v, input logic we, input logic [3:0] m,
                        input logic [7:0] a, input logic [31:0] d);
    m0_req_valid = v; m0_req_we = we; m0_req_wmask = m; m0_req_addr = a; m0_req_wdata = d;
  endtask

  task automatic set_m1(input logic v, input logic we, input logic [3:0] m,
                        input logic [7:0] a, input logic [31:0] d);
    m1_req_valid = v; m1_req_we = we; m1_req_wmask = m; m1_req_addr = a; m1_req_wdata = d;
  endtask

  function automatic logic [31:0] pre(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  int i0, i1;
  logic exp_m1;

  initial begin
    // Held in reset: nothing may reach the macro, even with a request pending.
    cyc();
    chk("rst_csb", 32'(sram_csb0), 32'd1);
    chk("rst_web", 32'(sram_web0), 32'd1);
    chk("rst_m0_rsp_valid", 32'(m0_rsp_valid), 32'd0);
    chk("rst_m1_rsp_valid", 32'(m1_rsp_valid), 32'd0);
    chk("rst_m0_rdata", m0_rsp_rdata, 32'd0);
    chk("rst_m1_err", 32'(m1_rsp_err), 32'd0);
    m0_req_valid = 1'b1;
    #1;
    chk("rst_req_csb", 32'(sram_csb0), 32'd1);
    chk("rst_req_ready", 32'(m0_req_ready), 32'd0);
    m0_req_valid = 1'b0;
    cyc();
    wb_rst_i = 1'b0;

    // Reset mid-flight: the in-flight read must never respond.
    cyc();
    set_m0(1, 0, 4'h0, 8'h05, 32'h0);
    #1;
    chk("mf_ready0", 32'(m0_req_ready), 32'd1);
    chk("mf_csb", 32'(sram_csb0), 32'd0);
    chk("mf_web", 32'(sram_web0), 32'd1);
    cyc();
    set_m0(0, 0, 4'h0, 8'h00, 32'h0);
    wb_rst_i = 1'b1;
    #1;
    chk("mf_rst_csb", 32'(sram_csb0), 32'd1);
    chk("mf_rsp_t1", 32'(m0_rsp_valid), 32'd0);
    cyc();
    wb_rst_i = 1'b0;
    chk("mf_rsp_t2", 32'(m0_rsp_valid), 32'd0);
    cyc();
    chk("mf_rsp_t3", 32'(m0_rsp_valid), 32'd0);

    // Full write then read-back of 0x10.
    set_m0(1, 1, 4'hF, 8'h10, 32'hDEADBEEF);
    #1;
    chk("w_ready0", 32'(m0_req_ready), 32'd1);
    chk("w_csb", 32'(sram_csb0), 32'd0);
    chk("w_web", 32'(sram_web0), 32'd0);
    chk("w_addr", 32'(sram_addr0), 32'h10);
    chk("w_din", sram_din0, 32'hDEADBEEF);
    chk("w_wmask", 32'(sram_wmask0), 32'hF);
    cyc();
    set_m0(1, 0, 4'h0, 8'h10, 32'h0);
    #1;
    chk("r_ready0", 32'(m0_req_ready), 32'd1);
    chk("r_web", 32'(sram_web0), 32'd1);
    cyc();
    set_m0(0, 0, 4'h0, 8'h00, 32'h0);
    #1;
    chk("wack_valid", 32'(m0_rsp_valid), 32'd1);
    chk("wack_rdata", m0_rsp_rdata, 32'd0);
    chk("wack_err", 32'(m0_rsp_err), 32'd0);
    chk("wack_m1_idle", 32'(m1_rsp_valid), 32'd0);
    chk("idle_csb", 32'(sram_csb0), 32'd1);
    chk("idle_addr_hold", 32'(sram_addr0), 32'h10);
    cyc();
    chk("rd_valid", 32'(m0_rsp_valid), 32'd1);
    chk("rd_rdata", m0_rsp_rdata, 32'hDEADBEEF);
    chk("rd_err", 32'(m0_rsp_err), 32'd0);
    cyc();
    chk("rd_after_valid", 32'(m0_rsp_valid), 32'd0);

    // Byte-lane 2 partial write.
    set_m0(1, 1, 4'b0100, 8'h10, 32'h00AA0000);
    cyc();
    set_m0(1, 0, 4'h0, 8'h10, 32'h0);
    cyc();
    set_m0(0, 0, 4'h0, 8'h00, 32'h0);
    cyc();
    chk("pw_rdata", m0_rsp_rdata, 32'hDEAABEEF);
    chk("pw_valid", 32'(m0_rsp_valid), 32'd1);

    // Preload words for later reads.
    for (int i = 0; i < 6; i++) begin
      set_m0(1, 1, 4'hF, 8'(8'h40 + i), pre(i));
      cyc();
    end
    set_m0(1, 1, 4'hF, 8'h20, 32'hCAFEF00D);
    cyc();
    set_m0(0, 0, 4'h0, 8'h00, 32'h0);
    cyc(); cyc(); cyc();

    // Write-protected m1 write: acknowledged with err, macro untouched.
    set_m1(1, 1, 4'hF, 8'h20, 32'h12345678);
    m1_wprot = 1'b1;
    #1;
    chk("wp_ready1", 32'(m1_req_ready), 32'd1);
    chk("wp_csb", 32'(sram_csb0), 32'd1);
    cyc();
    set_m1(0, 0, 4'h0, 8'h00, 32'h0);
    m1_wprot = 1'b0;
    cyc();
    chk("wp_valid", 32'(m1_rsp_valid), 32'd1);
    chk("wp_err", 32'(m1_rsp_err), 32'd1);
    chk("wp_rdata", m1_rsp_rdata, 32'd0);
    chk("wp_m0_idle", 32'(m0_rsp_valid), 32'd0);
    cyc();
    set_m1(1, 0, 4'h0, 8'h20, 32'h0);
    #1;
    chk("wpr_ready1", 32'(m1_req_ready), 32'd1);
    cyc();
    set_m1(0, 0, 4'h0, 8'h00, 32'h0);
    cyc();
    chk("wpr_rdata", m1_rsp_rdata, 32'hCAFEF00D);
    chk("wpr_err", 32'(m1_rsp_err), 32'd0);

    // Both requesters streaming reads; last grant was m1 so m0 wins first.
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 8; k++) begin
      set_m0(i0 < 3, 0, 4'h0, 8'(8'h40 + 2 * i0), 32'h0);
      set_m1(i1 < 3, 0, 4'h0, 8'(8'h41 + 2 * i1), 32'h0);
      #1;
      if (k < 6) begin
        exp_m1 = k[0];
        chk($sformatf("rr_ready0_%0d", k), 32'(m0_req_ready), 32'(!exp_m1));
        chk($sformatf("rr_ready1_%0d", k), 32'(m1_req_ready), 32'(exp_m1));
        chk($sformatf("rr_addr_%0d", k), 32'(sram_addr0), 32'h40 + 32'(k));
        if (exp_m1) i1++; else i0++;
      end
      if (k >= 2) begin
        if ((k - 2) % 2 == 0) begin
          chk($sformatf("rr_m0_valid_%0d", k - 2), 32'(m0_rsp_valid), 32'd1);
          chk($sformatf("rr_m0_rdata_%0d", k - 2), m0_rsp_rdata, pre(k - 2));
          chk($sformatf("rr_m1_quiet_%0d", k - 2), 32'(m1_rsp_valid) | m1_rsp_rdata, 32'd0);
        end else begin
          chk($sformatf("rr_m1_valid_%0d", k - 2), 32'(m1_rsp_valid), 32'd1);
          chk($sformatf("rr_m1_rdata_%0d", k - 2), m1_rsp_rdata, pre(k - 2));
          chk($sformatf("rr_m0_quiet_%0d", k - 2), 32'(m0_rsp_valid) | m0_rsp_rdata, 32'd0);
        end
      end
      cyc();
    end

    // Write by m0 immediately followed by m1 read of the same word.
    set_m0(1, 1, 4'hF, 8'h30, 32'h5A5A5A5A);
    set_m1(0, 0, 4'h0, 8'h00, 32'h0);
    #1;
    chk("hz_ready0", 32'(m0_req_ready), 32'd1);
    cyc();
    set_m0(0, 0, 4'h0, 8'h00, 32'h0);
    set_m1(1, 0, 4'h0, 8'h30, 32'h0);
    #1;
    chk("hz_ready1", 32'(m1_req_ready), 32'd1);
    cyc();
    set_m1(0, 0, 4'h0, 8'h00, 32'h0);
    chk("hz_wack", 32'(m0_rsp_valid), 32'd1);
    cyc();
    chk("hz_m1_valid", 32'(m1_rsp_valid), 32'd1);
    chk("hz_m1_rdata", m1_rsp_rdata, 32'h5A5A5A5A);
    chk("hz_m0_quiet", 32'(m0_rsp_valid), 32'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
